// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional counters in the top are enabled by the PIPE_PERF_CNT_EN macro.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned FUNCT_W = 4;
    localparam int unsigned F3_W    = 3;
    localparam int unsigned STATE_W = 2;
    localparam int unsigned CNT_W   = 32;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2,
        ST_BR_FLUSH   = 2'd3
    } state_e;

    localparam logic [F3_W-1:0] BEQ = 3'b000;
    localparam logic [F3_W-1:0] BNE = 3'b001;
    localparam logic [F3_W-1:0] BLT = 3'b100;
    localparam logic [F3_W-1:0] BGE = 3'b101;

    // Bundle of pipeline sequencing controls
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic pipe_hold;
        logic pc_src;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_DEFAULT = '{
        pc_write: 1'b1, ifid_write: 1'b1, pipe_hold: 1'b0, pc_src: 1'b0,
        ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0
    };

    localparam pipe_ctrl_t CTRL_MEM_HOLD = '{
        pc_write: 1'b0, ifid_write: 1'b0, pipe_hold: 1'b1, pc_src: 1'b0,
        ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0
    };

    // Taken branch redirects the PC and squashes the three younger stages
    localparam pipe_ctrl_t CTRL_BRANCH = '{
        pc_write: 1'b1, ifid_write: 1'b1, pipe_hold: 1'b0, pc_src: 1'b1,
        ifid_flush: 1'b1, idex_flush: 1'b1, exmem_flush: 1'b1
    };

    localparam pipe_ctrl_t CTRL_LOAD_STALL = '{
        pc_write: 1'b0, ifid_write: 1'b0, pipe_hold: 1'b0, pc_src: 1'b0,
        ifid_flush: 1'b0, idex_flush: 1'b1, exmem_flush: 1'b0
    };

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch condition evaluation for the instruction in EX/MEM.
module branch_resolve
    import pipe_ctrl_pkg::*;
(
    input  logic               Branch,
    input  logic               Zero,
    input  logic               Is_Greater,
    input  logic [FUNCT_W-1:0] funct,
    output logic               taken
);

    logic cond;
    logic unused_funct_hi;

    // Only funct3 selects the comparison; the upper bit carries no meaning here
    assign unused_funct_hi = funct[FUNCT_W-1];

    always_comb begin
        cond = 1'b0;
        case (funct[F3_W-1:0])
            BEQ:     cond = Zero;
            BNE:     cond = ~Zero;
            BLT:     cond = ~Is_Greater & ~Zero;
            BGE:     cond = Is_Greater | Zero;
            default: cond = 1'b0;
        endcase
    end

    assign taken = Branch & cond;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use, branch-flush and memory-wait sequencing for a 5-stage pipeline.
// Define PIPE_PERF_CNT_EN to add saturating stall/flush event counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [REG_W-1:0]   ifid_rs1,
    input  logic [REG_W-1:0]   ifid_rs2,
    input  logic               idex_MemRead,
    input  logic [REG_W-1:0]   idex_rd,
    input  logic               exmem_Branch,
    input  logic               exmem_Zero,
    input  logic               exmem_Is_Greater,
    input  logic [FUNCT_W-1:0] exmem_funct,
    input  logic               exmem_MemRead,
    input  logic               exmem_MemWrite,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               pipe_hold,
    output logic               pc_src,
    output logic               ifid_flush,
    output logic               idex_flush,
    output logic               exmem_flush,
    output logic [STATE_W-1:0] state_o
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
`endif
);

    state_e     state_q;
    state_e     state_d;
    pipe_ctrl_t ctrl;
    logic       branch_taken;
    logic       mem_busy;
    logic       load_use;

    branch_resolve u_branch_resolve (
        .Branch     (exmem_Branch),
        .Zero       (exmem_Zero),
        .Is_Greater (exmem_Is_Greater),
        .funct      (exmem_funct),
        .taken      (branch_taken)
    );

    assign mem_busy = (exmem_MemRead | exmem_MemWrite) & ~mem_ready;
    assign load_use = idex_MemRead & (idex_rd != '0)
                    & ((idex_rd == ifid_rs1) | (idex_rd == ifid_rs2));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Event priority: memory wait, then branch redirect, then load-use bubble
    always_comb begin
        state_d = state_q;
        ctrl    = CTRL_DEFAULT;
        case (state_q)
            ST_RUN: begin
                if (mem_busy) begin
                    ctrl    = CTRL_MEM_HOLD;
                    state_d = ST_MEM_WAIT;
                end else if (branch_taken) begin
                    ctrl    = CTRL_BRANCH;
                    state_d = ST_BR_FLUSH;
                end else if (load_use) begin
                    ctrl    = CTRL_LOAD_STALL;
                    state_d = ST_LOAD_STALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD_STALL: begin
                if (mem_busy) begin
                    ctrl    = CTRL_MEM_HOLD;
                    state_d = ST_MEM_WAIT;
                end else if (branch_taken) begin
                    ctrl    = CTRL_BRANCH;
                    state_d = ST_BR_FLUSH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_busy) begin
                    ctrl    = CTRL_MEM_HOLD;
                    state_d = ST_MEM_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_BR_FLUSH: begin
                if (mem_busy) begin
                    ctrl    = CTRL_MEM_HOLD;
                    state_d = ST_MEM_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign pc_write    = ctrl.pc_write;
    assign ifid_write  = ctrl.ifid_write;
    assign pipe_hold   = ctrl.pipe_hold;
    assign pc_src      = ctrl.pc_src;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_flush  = ctrl.idex_flush;
    assign exmem_flush = ctrl.exmem_flush;
    assign state_o     = STATE_W'(state_q);

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!ctrl.pc_write) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (ctrl.exmem_flush) begin
                flush_cnt <= sat_inc(flush_cnt);
            end
        end
    end
`else
    // Event counters are not built in this configuration
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed test of pipeline_hazard_ctrl: load-use, branch, memory wait, reset.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
    logic       idex_MemRead;
    logic       exmem_Branch, exmem_Zero, exmem_Is_Greater;
    logic [3:0] exmem_funct;
    logic       exmem_MemRead, exmem_MemWrite, mem_ready;
    logic       pc_write, ifid_write, pipe_hold, pc_src;
    logic       ifid_flush, idex_flush, exmem_flush;
    logic [1:0] state_o;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // {pc_write, ifid_write, pipe_hold, pc_src, ifid_flush, idex_flush, exmem_flush}
    logic [6:0] ctrl_v;
    assign ctrl_v = {pc_write, ifid_write, pipe_hold, pc_src, ifid_flush, idex_flush, exmem_flush};

    localparam logic [6:0] EXP_DEF    = 7'b1100000;
    localparam logic [6:0] EXP_LOAD   = 7'b0000010;
    localparam logic [6:0] EXP_BRANCH = 7'b1101111;
    localparam logic [6:0] EXP_HOLD   = 7'b0010000;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .ifid_rs1         (ifid_rs1),
        .ifid_rs2         (ifid_rs2),
        .idex_MemRead     (idex_MemRead),
        .idex_rd          (idex_rd),
        .exmem_Branch     (exmem_Branch),
        .exmem_Zero       (exmem_Zero),
        .exmem_Is_Greater (exmem_Is_Greater),
        .exmem_funct      (exmem_funct),
        .exmem_MemRead    (exmem_MemRead),
        .exmem_MemWrite   (exmem_MemWrite),
        .mem_ready        (mem_ready),
        .pc_write         (pc_write),
        .ifid_write       (ifid_write),
        .pipe_hold        (pipe_hold),
        .pc_src           (pc_src),
        .ifid_flush       (ifid_flush),
        .idex_flush       (idex_flush),
        .exmem_flush      (exmem_flush),
        .state_o          (state_o)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt)
`endif
    );

    task automatic idle();
        ifid_rs1 = '0; ifid_rs2 = '0; idex_rd = '0; idex_MemRead = 1'b0;
        exmem_Branch = 1'b0; exmem_Zero = 1'b0; exmem_Is_Greater = 1'b0;
        exmem_funct = '0; exmem_MemRead = 1'b0; exmem_MemWrite = 1'b0;
        mem_ready = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        #2;
        checks++;
        if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_o); end
        checks++;
        if (ctrl_v !== EXP_DEF) begin errors++; $display("FAIL reset_ctrl got %b exp %b", ctrl_v, EXP_DEF); end
`ifdef PIPE_PERF_CNT_EN
        checks++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", stall_cnt, flush_cnt);
        end
`endif
        step();
        reset_n = 1'b1;
        step();
        checks++;
        if (state_o !== 2'd0) begin errors++; $display("FAIL post_reset_state got %0d exp 0", state_o); end
    endtask

    task automatic test_load_use();
        idle();
        idex_MemRead = 1'b1; idex_rd = 5'd5; ifid_rs1 = 5'd3; ifid_rs2 = 5'd5;
        #1;
        checks++;
        if (ctrl_v !== EXP_LOAD) begin errors++; $display("FAIL load_stall_ctrl got %b exp %b", ctrl_v, EXP_LOAD); end
        step();
        checks++;
        if (state_o !== 2'd1) begin errors++; $display("FAIL load_stall_state got %0d exp 1", state_o); end
        checks++;
        if (ctrl_v !== EXP_DEF) begin errors++; $display("FAIL load_stall_ignored got %b exp %b", ctrl_v, EXP_DEF); end
        idle();
        step();
        checks++;
        if (state_o !== 2'd0) begin errors++; $display("FAIL load_release_state got %0d exp 0", state_o); end
        // rs1 match and a non-matching destination, decoded in RUN
        idex_MemRead = 1'b1; idex_rd = 5'd7; ifid_rs1 = 5'd7; ifid_rs2 = 5'd0;
        #1;
        checks++;
        if (ctrl_v !== EXP_LOAD) begin errors++; $display("FAIL load_rs1_ctrl got %b exp %b", ctrl_v, EXP_LOAD); end
        idex_rd = 5'd6;
        #1;
        checks++;
        if (ctrl_v !== EXP_DEF) begin errors++; $display("FAIL load_nomatch_ctrl got %b exp %b", ctrl_v, EXP_DEF); end
        idle();
        #1;
    endtask

    task automatic test_load_rd0();
        idle();
        idex_MemRead = 1'b1; idex_rd = 5'd0; ifid_rs1 = 5'd0; ifid_rs2 = 5'd0;
        #1;
        checks++;
        if (ctrl_v !== EXP_DEF) begin errors++; $display("FAIL rd0_ctrl got %b exp %b", ctrl_v, EXP_DEF); end
        step();
        checks++;
        if (state_o !== 2'd0) begin errors++; $display("FAIL rd0_state got %0d exp 0", state_o); end
        idle();
        #1;
    endtask

    task automatic test_branch_conds();
        // {Branch, Zero, Is_Greater, funct[3:0], expected taken}
        logic [7:0] vec [11];
        vec = '{8'b1_1_0_0000_1, 8'b1_0_0_0000_0, 8'b1_0_0_0001_1, 8'b1_1_0_0001_0,
                8'b1_0_0_0100_1, 8'b1_0_1_0100_0, 8'b1_0_0_0101_0, 8'b1_0_1_0101_1,
                8'b1_1_0_0010_0, 8'b0_1_0_0000_0, 8'b1_1_0_1000_1};
        idle();
        for (int i = 0; i < 11; i++) begin
            exmem_Branch     = vec[i][7];
            exmem_Zero       = vec[i][6];
            exmem_Is_Greater = vec[i][5];
            exmem_funct      = vec[i][4:1];
            #1;
            checks++;
            if (pc_src !== vec[i][0] || exmem_flush !== vec[i][0]) begin
                errors++;
                $display("FAIL branch_cond[%0d] got pc_src=%b exmem_flush=%b exp %b",
                         i, pc_src, exmem_flush, vec[i][0]);
            end
        end
        idle();
        #1;
    endtask

    task automatic test_branch();
        idle();
        exmem_Branch = 1'b1; exmem_funct = 4'b0001; exmem_Zero = 1'b0;
        #1;
        checks++;
        if (ctrl_v !== EXP_BRANCH) begin errors++; $display("FAIL branch_ctrl got %b exp %b", ctrl_v, EXP_BRANCH); end
        step();
        // branch and load-use both present in BR_FLUSH must be ignored
        idex_MemRead = 1'b1; idex_rd = 5'd4; ifid_rs1 = 5'd4;
        #1;
        checks++;
        if (state_o !== 2'd3) begin errors++; $display("FAIL br_flush_state got %0d exp 3", state_o); end
        checks++;
        if (ctrl_v !== EXP_DEF) begin errors++; $display("FAIL br_flush_ctrl got %b exp %b", ctrl_v, EXP_DEF); end
        idle();
        step();
        checks++;
        if (state_o !== 2'd0) begin errors++; $display("FAIL br_return_state got %0d exp 0", state_o); end
    endtask

    task automatic test_mem_wait();
        idle();
        exmem_MemRead = 1'b1; mem_ready = 1'b0;
        exmem_Branch = 1'b1; exmem_funct = 4'b0000; exmem_Zero = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ctrl_v !== EXP_HOLD || state_o !== ((i == 0) ? 2'd0 : 2'd2)) begin
                errors++;
                $display("FAIL mem_hold[%0d] got ctrl=%b state=%0d exp ctrl=%b", i, ctrl_v, state_o, EXP_HOLD);
            end
            step();
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (ctrl_v !== EXP_DEF || state_o !== 2'd2) begin
            errors++; $display("FAIL mem_ready_ctrl got ctrl=%b state=%0d exp ctrl=%b state=2", ctrl_v, state_o, EXP_DEF);
        end
        idle();
        step();
        checks++;
        if (state_o !== 2'd0) begin errors++; $display("FAIL mem_return_state got %0d exp 0", state_o); end
    endtask

    task automatic test_back_to_back();
        idle();
        idex_MemRead = 1'b1; idex_rd = 5'd9; ifid_rs2 = 5'd9;
        step();
        checks++;
        if (state_o !== 2'd1) begin errors++; $display("FAIL b2b_stall_state got %0d exp 1", state_o); end
        idle();
        exmem_Branch = 1'b1; exmem_funct = 4'b0100; exmem_Is_Greater = 1'b0; exmem_Zero = 1'b0;
        #1;
        checks++;
        if (ctrl_v !== EXP_BRANCH) begin errors++; $display("FAIL b2b_branch_ctrl got %b exp %b", ctrl_v, EXP_BRANCH); end
        step();
        idle();
        exmem_MemWrite = 1'b1; mem_ready = 1'b0;
        #1;
        checks++;
        if (ctrl_v !== EXP_HOLD || state_o !== 2'd3) begin
            errors++; $display("FAIL b2b_flush_hold got ctrl=%b state=%0d exp ctrl=%b state=3", ctrl_v, state_o, EXP_HOLD);
        end
        step();
        checks++;
        if (state_o !== 2'd2) begin errors++; $display("FAIL b2b_wait_state got %0d exp 2", state_o); end
        mem_ready = 1'b1;
        step();
        idle();
        checks++;
        if (state_o !== 2'd0) begin errors++; $display("FAIL b2b_return_state got %0d exp 0", state_o); end
    endtask

    task automatic test_reset_mid_wait();
        idle();
        exmem_MemRead = 1'b1; mem_ready = 1'b0;
        step();
        checks++;
        if (state_o !== 2'd2) begin errors++; $display("FAIL rst_wait_entry got %0d exp 2", state_o); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (state_o !== 2'd0) begin errors++; $display("FAIL rst_async_state got %0d exp 0", state_o); end
        checks++;
        if (ctrl_v !== EXP_HOLD) begin errors++; $display("FAIL rst_run_decode got %b exp %b", ctrl_v, EXP_HOLD); end
`ifdef PIPE_PERF_CNT_EN
        checks++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            errors++; $display("FAIL rst_async_cnt got %0d/%0d exp 0/0", stall_cnt, flush_cnt);
        end
`endif
        idle();
        step();
        reset_n = 1'b1;
        step();
        // re-issue the discarded access
        exmem_MemRead = 1'b1; mem_ready = 1'b0;
        step();
        checks++;
        if (state_o !== 2'd2) begin errors++; $display("FAIL rst_reissue_state got %0d exp 2", state_o); end
        mem_ready = 1'b1;
        step();
        idle();
        checks++;
        if (state_o !== 2'd0) begin errors++; $display("FAIL rst_reissue_done got %0d exp 0", state_o); end
    endtask

`ifdef PIPE_PERF_CNT_EN
    task automatic test_perf_cnt();
        idle();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        exmem_MemRead = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        mem_ready = 1'b1;
        step();
        idle();
        exmem_Branch = 1'b1; exmem_funct = 4'b0001; exmem_Zero = 1'b0;
        step();
        idle();
        step();
        checks++;
        if (stall_cnt !== 32'd4) begin errors++; $display("FAIL stall_cnt got %0d exp 4", stall_cnt); end
        checks++;
        if (flush_cnt !== 32'd1) begin errors++; $display("FAIL flush_cnt got %0d exp 1", flush_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_load_rd0();
        test_branch_conds();
        test_branch();
        test_mem_wait();
        test_back_to_back();
        test_reset_mid_wait();
`ifdef PIPE_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
